nonrestoring_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 18 +
 rtl/div_sign_unit.sv | 33 +++
 rtl/nonrestoring_divider.sv | 202 ++++++++++++++++++++
 tb/tb_nonrestoring_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential non-restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 4;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int div_count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sign_unit.sv
// Signed helper for the divider: operand magnitudes on the way in,
// sign restoration of quotient/remainder and overflow detect on the way out.
// Only instantiated when DIV_SIGNED_EN is defined.
module div_sign_unit
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [WIDTH-1:0] q_mag,
  input  logic [WIDTH-1:0] r_mag,
  output logic [WIDTH-1:0] a_abs,
  output logic [WIDTH-1:0] b_abs,
  output logic [WIDTH-1:0] q_res,
  output logic [WIDTH-1:0] r_res,
  output logic             q_ovf
);

  // Magnitudes are unsigned, so |min| = 2^(WIDTH-1) still fits.
  assign a_abs = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_abs = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Truncation toward zero: quotient sign is the XOR, remainder follows the dividend.
  assign q_res = (sign_a ^ sign_b) ? (~q_mag + 1'b1) : q_mag;
  assign r_res = sign_a ? (~r_mag + 1'b1) : r_mag;

  // A positive quotient with the top magnitude bit set only arises from min / -1.
  assign q_ovf = ~(sign_a ^ sign_b) & q_mag[WIDTH-1];

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider, one quotient bit per clock, sharing the
// start/ready handshake of the Booth multiplier.
// Build option: DIV_SIGNED_EN defined -> signed two's-complement operands;
// undefined -> unsigned operands, ovf tied low.
//
// state | meaning
// IDLE  | waiting for start, outputs cleared by reset
// ITER  | one shift/add-or-subtract step per clock, count runs down to 0
// FIX   | restore a negative partial remainder
// DONE  | first cycle publishes the result; afterwards holds it and accepts start
module nonrestoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             ready,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int CW = div_count_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] bm_q, bm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ready_q, ready_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs, q_res, r_res;
  logic             q_ovf;
  logic [WIDTH:0]   p_sh, p_new;

  // Partial remainder step; wraps mod 2^(WIDTH+1) but the post-step value always fits.
  assign p_sh  = {p_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign p_new = p_q[WIDTH] ? (p_sh + {1'b0, bm_q}) : (p_sh - {1'b0, bm_q});

`ifdef DIV_SIGNED_EN
  logic sa_q, sa_d, sb_q, sb_d;

  // Operand signs are latched only when an operation is accepted.
  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (accept) begin
      sa_d = A[WIDTH-1];
      sb_d = B[WIDTH-1];
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  div_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .a      (A),
    .b      (B),
    .sign_a (sa_q),
    .sign_b (sb_q),
    .q_mag  (qr_q),
    .r_mag  (p_q[WIDTH-1:0]),
    .a_abs  (a_abs),
    .b_abs  (b_abs),
    .q_res  (q_res),
    .r_res  (r_res),
    .q_ovf  (q_ovf)
  );
`else
  assign a_abs = A;
  assign b_abs = B;
  assign q_res = qr_q;
  assign r_res = p_q[WIDTH-1:0];
  assign q_ovf = 1'b0;
`endif

  // Next-state and datapath: iterate, restore, publish once, then accept new work.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    qr_d    = qr_q;
    bm_d    = bm_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    ready_d = ready_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      ITER: begin
        p_d   = p_new;
        qr_d  = {qr_q[WIDTH-2:0], ~p_new[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = FIX;
      end
      FIX: begin
        if (p_q[WIDTH]) p_d = p_q + {1'b0, bm_q};
        state_d = DONE;
      end
      DONE: begin
        // ready low here means the result has not been published yet.
        if (!ready_q) begin
          ready_d = 1'b1;
          if (dz_q) begin
            q_d   = '1;
            r_d   = p_q[WIDTH-1:0];
            dbz_d = 1'b1;
            ovf_d = 1'b0;
          end else begin
            q_d   = q_res;
            r_d   = r_res;
            dbz_d = 1'b0;
            ovf_d = q_ovf;
          end
        end else if (start) begin
          accept = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ready_d = 1'b0;
      dbz_d   = 1'b0;
      ovf_d   = 1'b0;
      qr_d    = a_abs;
      bm_d    = b_abs;
      cnt_d   = CNT_INIT;
      dz_d    = (B == '0);
      if (B == '0) begin
        // Raw dividend parked in P so it can be returned as the remainder.
        p_d     = {1'b0, A};
        state_d = DONE;
      end else begin
        p_d     = '0;
        state_d = ITER;
      end
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      qr_q    <= '0;
      bm_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      qr_q    <= qr_d;
      bm_q    <= bm_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign ready       = ready_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider, WIDTH=4. Expected values are hand
// computed; the signed or unsigned table is chosen by DIV_SIGNED_EN.
module tb_nonrestoring_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] A, B;
  logic [3:0] Q, R;
  logic       ready, div_by_zero, ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  nonrestoring_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, scramble the operands, count edges until ready.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = b + 4'd3;
    check("rdy_clr", ready, 1'b0);
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n_hi;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 6});
    vecs.push_back('{4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, 6});
    vecs.push_back('{4'hF, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1});
    vecs.push_back('{4'hA, 4'h3, 4'hE, 4'h0, 1'b0, 1'b0, 6});
`else
    vecs.push_back('{4'hF, 4'h4, 4'h3, 4'h3, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h9, 4'h2, 4'h4, 4'h1, 1'b0, 1'b0, 6});
    vecs.push_back('{4'hD, 4'hF, 4'h0, 4'hD, 1'b0, 1'b0, 6});
    vecs.push_back('{4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 1});
    vecs.push_back('{4'hE, 4'h7, 4'h2, 4'h0, 1'b0, 1'b0, 6});
`endif

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_q", Q, 4'h0);
    check("rst_r", R, 4'h0);
    check("rst_rdy", ready, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("lat_%0d", i), lat, vecs[i].lat);
      check($sformatf("q_%0d", i), Q, vecs[i].q);
      check($sformatf("r_%0d", i), R, vecs[i].r);
      check($sformatf("dbz_%0d", i), div_by_zero, vecs[i].dz);
      check($sformatf("ovf_%0d", i), ovf, vecs[i].ov);
    end

    // Reset in the middle of an iteration.
    @(negedge clk);
    A = 4'h7;
    B = 4'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_q", Q, 4'h0);
    check("mid_rst_r", R, 4'h0);
    check("mid_rst_rdy", ready, 1'b0);
    check("mid_rst_dbz", div_by_zero, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    do_op(4'h6, 4'h3, lat);
    check("post_rst_lat", lat, 6);
    check("post_rst_q", Q, 4'h2);
    check("post_rst_r", R, 4'h0);

    // Start pulsed mid-iteration is ignored; outputs hold during ITER.
    @(negedge clk);
    A = 4'h7;
    B = 4'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 4'h1;
    B = 4'h1;
    @(posedge clk);
    #1;
    check("iter_q_hold", Q, 4'h2);
    check("iter_rdy", ready, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 2;
    while (!ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_lat", lat, 6);
    check("ign_q", Q, 4'h3);
    check("ign_r", R, 4'h1);

    // Start held high: one-cycle ready per result, back-to-back operations.
    @(negedge clk);
    A = 4'h7;
    B = 4'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_hi = 0;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk);
      #1;
      if (ready) n_hi++;
      if (i == 7) check("held_rdy_drop", ready, 1'b0);
    end
    check("held_pulses", n_hi, 2);
    check("held_rdy_end", ready, 1'b1);
    check("held_q", Q, 4'h3);
    check("held_r", R, 4'h1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_idle_rdy", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
